// File: rtl/mux16_1_16b_arb.sv
// 16:1 gathering mux with a one-entry registered output stage and lane arbiter.
// Define MUX_RR_ARB_EN for round-robin arbitration; default build is fixed priority (lane 0 highest).
module mux16_1_16b_arb #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] x_0,
    input  logic [DW-1:0] x_1,
    input  logic [DW-1:0] x_2,
    input  logic [DW-1:0] x_3,
    input  logic [DW-1:0] x_4,
    input  logic [DW-1:0] x_5,
    input  logic [DW-1:0] x_6,
    input  logic [DW-1:0] x_7,
    input  logic [DW-1:0] x_8,
    input  logic [DW-1:0] x_9,
    input  logic [DW-1:0] x_10,
    input  logic [DW-1:0] x_11,
    input  logic [DW-1:0] x_12,
    input  logic [DW-1:0] x_13,
    input  logic [DW-1:0] x_14,
    input  logic [DW-1:0] x_15,
    input  logic [15:0]   vld,
    output logic [15:0]   ack,
    output logic [DW-1:0] Y,
    output logic          Y_vld,
    input  logic          Y_rdy,
    output logic          Sel3,
    output logic          Sel2,
    output logic          Sel1,
    output logic          Sel0
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [DW-1:0] lanes_s [16];
    logic [3:0]    search_base_s;
    logic [4:0]    pick_s;
    logic [3:0]    grant_s;
    logic          any_req_s;
    logic          can_load_s;
    logic          load_s;
    logic [0:0]    state_r;
    logic [0:0]    state_next_s;
    logic [DW-1:0] y_r;
    logic [3:0]    sel_r;

    // First requesting lane at or after base, wrapping 15 -> 0; returns {hit, index}.
    function automatic logic [4:0] pick_lane(input logic [15:0] req, input logic [3:0] base);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       hit;
        pick = 4'd0;
        hit  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = base + 4'(k);
            if (!hit && req[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return {hit, pick};
    endfunction

    assign lanes_s[0]  = x_0;
    assign lanes_s[1]  = x_1;
    assign lanes_s[2]  = x_2;
    assign lanes_s[3]  = x_3;
    assign lanes_s[4]  = x_4;
    assign lanes_s[5]  = x_5;
    assign lanes_s[6]  = x_6;
    assign lanes_s[7]  = x_7;
    assign lanes_s[8]  = x_8;
    assign lanes_s[9]  = x_9;
    assign lanes_s[10] = x_10;
    assign lanes_s[11] = x_11;
    assign lanes_s[12] = x_12;
    assign lanes_s[13] = x_13;
    assign lanes_s[14] = x_14;
    assign lanes_s[15] = x_15;

`ifdef MUX_RR_ARB_EN
    logic [3:0] ptr_r;

    // Round-robin pointer: moves past the granted lane, only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 4'd0;
        end else if (load_s) begin
            ptr_r <= grant_s + 4'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign search_base_s = ptr_r;
`else
    assign search_base_s = 4'd0;
`endif

    assign pick_s    = pick_lane(vld, search_base_s);
    assign any_req_s = pick_s[4];
    assign grant_s   = pick_s[3:0];

    // Stage can accept a word when empty, or when full and draining this cycle.
    always_comb begin
        case (state_r)
            ST_EMPTY: can_load_s = 1'b1;
            ST_FULL:  can_load_s = Y_rdy;
            default:  can_load_s = 1'b0;
        endcase
    end

    // rst_n gates the grant so ack is silent throughout reset.
    assign load_s = rst_n & can_load_s & any_req_s;

    // One-hot acknowledge of the lane captured at the coming edge.
    always_comb begin
        if (load_s) begin
            ack = 16'h0001 << grant_s;
        end else begin
            ack = 16'h0000;
        end
    end

    // Next state: refill wins over drain; a drained stage with no request goes empty.
    always_comb begin
        if (load_s) begin
            state_next_s = ST_FULL;
        end else if (can_load_s) begin
            state_next_s = ST_EMPTY;
        end else begin
            state_next_s = state_r;
        end
    end

    // Output register: word and source index held stable while not loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            y_r     <= '0;
            sel_r   <= 4'd0;
        end else if (load_s) begin
            state_r <= state_next_s;
            y_r     <= lanes_s[grant_s];
            sel_r   <= grant_s;
        end else begin
            state_r <= state_next_s;
            y_r     <= y_r;
            sel_r   <= sel_r;
        end
    end

    assign Y     = y_r;
    assign Y_vld = (state_r == ST_FULL);
    assign Sel3  = sel_r[3];
    assign Sel2  = sel_r[2];
    assign Sel1  = sel_r[1];
    assign Sel0  = sel_r[0];

endmodule

// File: tb/tb_mux16_1_16b_arb.sv
// Directed bench for mux16_1_16b_arb; expectations follow MUX_RR_ARB_EN if defined.
module tb_mux16_1_16b_arb;

    logic        clk;
    logic        rst_n;
    logic [15:0] x_s [16];
    logic [15:0] vld;
    logic [15:0] ack;
    logic [15:0] Y;
    logic        Y_vld;
    logic        Y_rdy;
    logic        Sel3, Sel2, Sel1, Sel0;
    logic [3:0]  sel_w;

    int checks   = 0;
    int failures = 0;

    int          rx_cnt [16];
    logic [15:0] rx_val [16];
    logic [15:0] pending;
    int          done_cyc;
    int          g1, g2;
    logic [15:0] y2_exp;

    assign sel_w = {Sel3, Sel2, Sel1, Sel0};

    mux16_1_16b_arb #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_0(x_s[0]),   .x_1(x_s[1]),   .x_2(x_s[2]),   .x_3(x_s[3]),
        .x_4(x_s[4]),   .x_5(x_s[5]),   .x_6(x_s[6]),   .x_7(x_s[7]),
        .x_8(x_s[8]),   .x_9(x_s[9]),   .x_10(x_s[10]), .x_11(x_s[11]),
        .x_12(x_s[12]), .x_13(x_s[13]), .x_14(x_s[14]), .x_15(x_s[15]),
        .vld(vld), .ack(ack), .Y(Y), .Y_vld(Y_vld), .Y_rdy(Y_rdy),
        .Sel3(Sel3), .Sel2(Sel2), .Sel1(Sel1), .Sel0(Sel0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        Y_rdy = 1'b0;
        vld   = 16'hFFFF;
        for (int i = 0; i < 16; i++) x_s[i] = 16'h0000;

        // Reset: outputs and ack all zero even with every lane requesting
        #12;
        check_eq("rst_y",     32'(Y),     32'h0);
        check_eq("rst_y_vld", 32'(Y_vld), 32'h0);
        check_eq("rst_sel",   32'(sel_w), 32'h0);
        check_eq("rst_ack",   32'(ack),   32'h0);
        vld   = 16'h0000;
        rst_n = 1'b1;

        // Single lane 5
        x_s[5] = 16'hBEEF;
        vld    = 16'h0020;
        Y_rdy  = 1'b1;
        #1;
        check_eq("single_ack", 32'(ack), 32'h0020);
        tick();
        check_eq("single_y",     32'(Y),     32'hBEEF);
        check_eq("single_y_vld", 32'(Y_vld), 32'h1);
        check_eq("single_sel",   32'(sel_w), 32'h5);
        vld = 16'h0000;
        #1;
        check_eq("drain_ack", 32'(ack), 32'h0);
        tick();
        check_eq("drain_y_vld", 32'(Y_vld), 32'h0);

        // Backpressure with all lanes requesting
`ifdef MUX_RR_ARB_EN
        g1 = 6;
        g2 = 7;
`else
        g1 = 0;
        g2 = 0;
`endif
        for (int i = 0; i < 16; i++) x_s[i] = 16'h2000 + 16'(i);
        vld = 16'hFFFF;
        #1;
        check_eq("bp_ack1", 32'(ack), 32'(16'h0001 << g1));
        tick();
        check_eq("bp_y1",   32'(Y),     32'(16'h2000 + 16'(g1)));
        check_eq("bp_sel1", 32'(sel_w), 32'(g1));
        x_s[g1] = 16'h3000 + 16'(g1);
        y2_exp  = (g2 == g1) ? (16'h3000 + 16'(g1)) : (16'h2000 + 16'(g2));
        Y_rdy   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("bp_ack_hold", 32'(ack), 32'h0);
            tick();
            check_eq("bp_y_hold",   32'(Y),     32'(16'h2000 + 16'(g1)));
            check_eq("bp_sel_hold", 32'(sel_w), 32'(g1));
            check_eq("bp_vld_hold", 32'(Y_vld), 32'h1);
        end
        Y_rdy = 1'b1;
        #1;
        check_eq("bp_ack2", 32'(ack), 32'(16'h0001 << g2));
        tick();
        check_eq("bp_y2",   32'(Y),     32'(y2_exp));
        check_eq("bp_sel2", 32'(sel_w), 32'(g2));

        // Reset mid-transfer with a held word: cleared without a clock edge
        Y_rdy = 1'b0;
        vld   = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_y",     32'(Y),     32'h0);
        check_eq("mid_rst_y_vld", 32'(Y_vld), 32'h0);
        check_eq("mid_rst_sel",   32'(sel_w), 32'h0);
        check_eq("mid_rst_ack",   32'(ack),   32'h0);
        vld = 16'h0000;
        #1;
        rst_n = 1'b1;

        // Lanes 0 and 15 held: wrap for round-robin, lane 0 only for fixed priority
        x_s[0]  = 16'h0A00;
        x_s[15] = 16'h0A0F;
        vld     = 16'h8001;
        Y_rdy   = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MUX_RR_ARB_EN
            g1 = ((k % 2) == 1) ? 15 : 0;
`else
            g1 = 0;
`endif
            #1;
            check_eq("wrap_ack", 32'(ack), 32'(16'h0001 << g1));
            tick();
            check_eq("wrap_sel", 32'(sel_w), 32'(g1));
            check_eq("wrap_y",   32'(Y),     32'(16'h0A00 + 16'(g1)));
        end
        vld = 16'h0000;
        tick();

        // Round trip through a behavioural demux keyed on Sel
        for (int i = 0; i < 16; i++) begin
            x_s[i]    = 16'h1000 + 16'(i);
            rx_cnt[i] = 0;
            rx_val[i] = 16'h0000;
        end
        pending  = 16'hFFFF;
        done_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            vld = pending;
            #1;
            if (pending != 16'h0000) check_eq("rt_onehot", 32'($countones(ack)), 32'h1);
            pending = pending & ~ack;
            tick();
            if (Y_vld) begin
                rx_cnt[sel_w]++;
                rx_val[sel_w] = Y;
            end else if (pending == 16'h0000) begin
                done_cyc = cyc;
                break;
            end else begin
                done_cyc = done_cyc;
            end
        end
        check_eq("rt_cycles", 32'(done_cyc), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("rt_cnt_%0d", i), 32'(rx_cnt[i]), 32'd1);
            check_eq($sformatf("rt_val_%0d", i), 32'(rx_val[i]), 32'(16'h1000 + 16'(i)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
